sync_fifo: RTL and testbench

- Synchronous single-clock FIFO queuing 16-bit request words (e.g. memory read addresses) between a requester and the memory controller's sequencing state machine.
- Registered read data: a pop strobe sampled on one clock edge presents the head word on data_out after that edge.
- Full/empty flags let the producer detect overflow and the consumer poll for work.

---
 rtl/sync_fifo_ram.sv | 28 ++
 rtl/sync_fifo.sv | 93 +++++++++
 tb/tb_sync_fifo.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_ram.sv
// Storage array for sync_fifo: one synchronous write port and one asynchronous read port.
// Contents are never reset; the pointer and count logic in the parent decides what is valid.
module sync_fifo_ram #(
  parameter int PTR_BITS = 5,
  parameter int WIDTH    = 16
) (
  input  logic                clk,
  input  logic                i_we,
  input  logic [PTR_BITS-1:0] i_waddr,
  input  logic [WIDTH-1:0]    i_wdata,
  input  logic [PTR_BITS-1:0] i_raddr,
  output logic [WIDTH-1:0]    o_rdata
);

  localparam int DEPTH = 1 << PTR_BITS;

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // The read is combinational, so a same-cycle write never bypasses onto the read port.
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock request FIFO with registered read data, occupancy count and sticky error flags.
// Full and empty are decoded from the count, so equal pointers after a wrap are never ambiguous.
module sync_fifo #(
  parameter int PTR_BITS = 5,
  parameter int WIDTH    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic [WIDTH-1:0]    data_in,
  output logic                full,
  input  logic                pop,
  output logic [WIDTH-1:0]    data_out,
  output logic                empty,
  input  logic                flush,
  output logic [PTR_BITS:0]   count,
  output logic                overflow,
  output logic                underflow
);

  localparam int                DEPTH     = 1 << PTR_BITS;
  localparam logic [PTR_BITS:0] DEPTH_CNT = (PTR_BITS + 1)'(DEPTH);

  logic [PTR_BITS-1:0] r_wr_ptr;
  logic [PTR_BITS-1:0] r_rd_ptr;
  logic [PTR_BITS:0]   r_count;
  logic [WIDTH-1:0]    r_data_out;
  logic                r_overflow;
  logic                r_underflow;

  logic                w_pop_ok;
  logic                w_push_ok;
  logic                w_we;
  logic [WIDTH-1:0]    w_rdata;

  assign empty = (r_count == '0);
  assign full  = (r_count == DEPTH_CNT);

  // A push into a full FIFO is still accepted when a pop frees a slot in the same cycle.
  assign w_pop_ok  = pop && !empty;
  assign w_push_ok = push && (!full || w_pop_ok);
  assign w_we      = rst_n && !flush && w_push_ok;

  sync_fifo_ram #(
    .PTR_BITS (PTR_BITS),
    .WIDTH    (WIDTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (data_in),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_data_out  <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end else if (push) begin
        r_overflow <= 1'b1;
      end
      if (w_pop_ok) begin
        r_data_out <= w_rdata;
        r_rd_ptr   <= r_rd_ptr + 1'b1;
      end else if (pop) begin
        r_underflow <= 1'b1;
      end
      if (w_push_ok && !w_pop_ok) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop_ok && !w_push_ok) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign data_out  = r_data_out;
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: queue-based reference model checked every cycle, plus directed literal checks.
module tb_sync_fifo;

  localparam int PTR_BITS = 5;
  localparam int WIDTH    = 16;
  localparam int DEPTH    = 1 << PTR_BITS;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               push = 1'b0;
  logic               pop = 1'b0;
  logic               flush = 1'b0;
  logic [WIDTH-1:0]   data_in = '0;
  logic [WIDTH-1:0]   data_out;
  logic               full, empty, overflow, underflow;
  logic [PTR_BITS:0]  count;

  int checks = 0;
  int errors = 0;

  sync_fifo #(.PTR_BITS(PTR_BITS), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .data_in   (data_in),
    .full      (full),
    .pop       (pop),
    .data_out  (data_out),
    .empty     (empty),
    .flush     (flush),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of words plus the two sticky bits.
  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] m_dout = '0;
  logic             m_ovf = 1'b0;
  logic             m_unf = 1'b0;
  bit               started = 1'b0;

  always @(posedge clk) begin
    bit pop_ok, push_ok;
    if (!rst_n) begin
      m_q.delete();
      m_dout  = '0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      started = 1'b1;
    end else if (flush) begin
      m_q.delete();
    end else begin
      pop_ok  = pop && (m_q.size() > 0);
      push_ok = push && ((m_q.size() < DEPTH) || pop_ok);
      if (pop_ok) m_dout = m_q.pop_front();
      else if (pop) m_unf = 1'b1;
      if (push_ok) m_q.push_back(data_in);
      else if (push) m_ovf = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("model_count", 32'(count), 32'(m_q.size()));
      chk("model_empty", 32'(empty), 32'(m_q.size() == 0));
      chk("model_full", 32'(full), 32'(m_q.size() == DEPTH));
      chk("model_dout", 32'(data_out), 32'(m_dout));
      chk("model_ovf", 32'(overflow), 32'(m_ovf));
      chk("model_unf", 32'(underflow), 32'(m_unf));
    end
  end

  task automatic step(input logic p, input logic [WIDTH-1:0] d, input logic po,
                      input logic f, input logic r);
    push = p; data_in = d; pop = po; flush = f; rst_n = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: reset then idle
    step(0, 16'h0, 0, 0, 0);
    step(0, 16'h0, 0, 0, 1);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_dout", 32'(data_out), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_unf", 32'(underflow), 32'd0);

    // 2: three pushes then three pops
    step(1, 16'h0010, 0, 0, 1);
    chk("t2_not_empty", 32'(empty), 32'd0);
    step(1, 16'h0020, 0, 0, 1);
    step(1, 16'h0030, 0, 0, 1);
    chk("t2_count3", 32'(count), 32'd3);
    step(0, 16'h0, 1, 0, 1);
    chk("t2_pop0", 32'(data_out), 32'h0010);
    step(0, 16'h0, 1, 0, 1);
    chk("t2_pop1", 32'(data_out), 32'h0020);
    step(0, 16'h0, 1, 0, 1);
    chk("t2_pop2", 32'(data_out), 32'h0030);
    chk("t2_empty", 32'(empty), 32'd1);

    // 3: fill, overflow, drain
    for (int i = 0; i < DEPTH; i++) step(1, 16'h1000 + 16'(i), 0, 0, 1);
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_count", 32'(count), 32'd32);
    step(1, 16'hDEAD, 0, 0, 1);
    chk("t3_ovf", 32'(overflow), 32'd1);
    chk("t3_count_after", 32'(count), 32'd32);
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 16'h0, 1, 0, 1);
      chk("t3_drain", 32'(data_out), 32'h1000 + 32'(i));
    end
    chk("t3_empty", 32'(empty), 32'd1);

    // 4: interleaved traffic across the pointer wrap, occupancy at most 3
    for (int i = 0; i < 40; i++) begin
      step(1, 16'h2000 + 16'(i), (i >= 3), 0, 1);
      if (i >= 3) chk("t4_order", 32'(data_out), 32'h2000 + 32'(i - 3));
      chk("t4_count", 32'(count), (i >= 3) ? 32'd3 : 32'(i + 1));
    end
    for (int i = 37; i < 40; i++) begin
      step(0, 16'h0, 1, 0, 1);
      chk("t4_tail", 32'(data_out), 32'h2000 + 32'(i));
    end
    chk("t4_empty", 32'(empty), 32'd1);

    // 5: simultaneous push/pop at count 1, then pop on empty
    step(1, 16'h5555, 0, 0, 1);
    step(1, 16'hAAAA, 1, 0, 1);
    chk("t5_old_head", 32'(data_out), 32'h5555);
    chk("t5_count1", 32'(count), 32'd1);
    step(0, 16'h0, 1, 0, 1);
    chk("t5_second", 32'(data_out), 32'hAAAA);
    chk("t5_unf_before", 32'(underflow), 32'd0);
    step(0, 16'h0, 1, 0, 1);
    chk("t5_unf", 32'(underflow), 32'd1);
    chk("t5_dout_hold", 32'(data_out), 32'hAAAA);

    // 6: flush with concurrent push, then mid-operation reset
    for (int i = 0; i < 5; i++) step(1, 16'h3000 + 16'(i), 0, 0, 1);
    chk("t6_count5", 32'(count), 32'd5);
    step(1, 16'hBEEF, 0, 1, 1);
    chk("t6_flush_count", 32'(count), 32'd0);
    chk("t6_flush_empty", 32'(empty), 32'd1);
    chk("t6_flush_dout", 32'(data_out), 32'hAAAA);
    chk("t6_flush_sticky", 32'(underflow), 32'd1);
    step(1, 16'h4000, 0, 0, 1);
    step(1, 16'h4001, 1, 0, 1);
    chk("t6_after_flush", 32'(data_out), 32'h4000);
    step(1, 16'h4002, 1, 0, 0);
    chk("t6_rst_count", 32'(count), 32'd0);
    chk("t6_rst_empty", 32'(empty), 32'd1);
    chk("t6_rst_full", 32'(full), 32'd0);
    chk("t6_rst_dout", 32'(data_out), 32'h0);
    chk("t6_rst_ovf", 32'(overflow), 32'd0);
    chk("t6_rst_unf", 32'(underflow), 32'd0);
    step(0, 16'h0, 0, 0, 1);
    step(0, 16'h0, 0, 0, 1);
    @(negedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
